// File: rtl/entropy_src_pkg.sv
// Shared types and default sizing for the entropy source window-counter controller.
package entropy_src_pkg;

    localparam int NumCntrDefault  = 4;
    localparam int RegWidthDefault = 16;
    localparam int WinWidthDefault = 16;

    // One-hot encoding leaves most 4-bit patterns illegal, so a flipped bit is detectable.
    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StRun   = 4'b0010,
        StSnap  = 4'b0100,
        StClear = 4'b1000
    } state_e;

endpackage

// File: rtl/entropy_src_cntr_reg.sv
// Saturating event counter kept in two redundant copies; any disagreement raises err_o.
module entropy_src_cntr_reg #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] shadow_q, shadow_d;

    // Next count for both copies: clear wins, otherwise increment until all-ones.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (clr_i) begin
            cnt_d    = {Width{1'b0}};
            shadow_d = {Width{1'b0}};
        end else begin
            if (inc_i && (cnt_q != {Width{1'b1}})) begin
                cnt_d = cnt_q + One;
            end else begin
                cnt_d = cnt_q;
            end
            if (inc_i && (shadow_q != {Width{1'b1}})) begin
                shadow_d = shadow_q + One;
            end else begin
                shadow_d = shadow_q;
            end
        end
    end

    // Counter and shadow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= {Width{1'b0}};
            shadow_q <= {Width{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = (cnt_q != shadow_q);

endmodule

// File: rtl/entropy_src_cntr_win_ctrl.sv
// Windowed event counting: per-counter totals snapshotted at the end of each window,
// running watermarks, a software clear handshake and a sticky fatal error.
module entropy_src_cntr_win_ctrl
    import entropy_src_pkg::*;
#(
    parameter int NumCntr  = NumCntrDefault,
    parameter int RegWidth = RegWidthDefault,
    parameter int WinWidth = WinWidthDefault
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               enable_i,
    input  logic [WinWidth-1:0]                win_size_i,
    input  logic [NumCntr-1:0]                 event_i,
    input  logic                               sw_clr_req_i,
    output logic                               sw_clr_ack_o,
    output logic                               win_done_o,
    output logic [NumCntr-1:0][RegWidth-1:0]   snap_value_o,
    output logic [NumCntr-1:0][RegWidth-1:0]   watermark_o,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam logic [WinWidth-1:0] WinOne = {{(WinWidth-1){1'b0}}, 1'b1};

    state_e                             state_q, state_d;
    logic [WinWidth-1:0]                size_q, size_d;
    logic [WinWidth-1:0]                timer_q, timer_d;
    logic [NumCntr-1:0][RegWidth-1:0]   snap_q, snap_d;
    logic [NumCntr-1:0][RegWidth-1:0]   wm_q, wm_d;
    logic                               done_q, done_d;
    logic                               ack_q, ack_d;
    logic                               busy_q, busy_d;
    logic                               err_q, err_d;

    logic                               illegal_s;
    logic                               cnt_clr_s;
    logic [NumCntr-1:0]                 cnt_inc_s;
    logic [NumCntr-1:0][RegWidth-1:0]   cnt_s;
    logic [NumCntr-1:0]                 cntr_err_s;

    // Next-state selection; a clear request overrides everything except an ongoing clear.
    always_comb begin
        state_d   = state_q;
        illegal_s = 1'b0;
        case (state_q)
            StIdle, StSnap: begin
                if (enable_i && (win_size_i != {WinWidth{1'b0}})) begin
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (timer_q == (size_q - WinOne)) begin
                    state_d = StSnap;
                end else begin
                    state_d = StRun;
                end
            end
            StClear: state_d = StIdle;
            default: begin
                state_d   = StIdle;
                illegal_s = 1'b1;
            end
        endcase
        if (sw_clr_req_i && (state_q != StClear)) begin
            state_d = StClear;
        end else begin
            state_d = state_d;
        end
    end

    // Window bookkeeping, counter control, snapshot/watermark update and output flags.
    always_comb begin
        size_d    = size_q;
        timer_d   = {WinWidth{1'b0}};
        snap_d    = snap_q;
        wm_d      = wm_q;
        cnt_inc_s = {NumCntr{1'b0}};
        if ((state_q != StRun) && (state_d == StRun)) begin
            size_d = win_size_i;
        end else begin
            size_d = size_q;
        end
        if ((state_q == StRun) && (state_d == StRun)) begin
            timer_d = timer_q + WinOne;
        end else begin
            timer_d = {WinWidth{1'b0}};
        end
        if (state_q == StRun) begin
            cnt_inc_s = event_i;
        end else begin
            cnt_inc_s = {NumCntr{1'b0}};
        end
        cnt_clr_s = (state_q == StSnap) || (state_q == StClear) ||
                    ((state_q == StRun) && (state_d == StIdle));
        if (state_d == StClear) begin
            snap_d = '0;
            wm_d   = '0;
        end else if (state_q == StSnap) begin
            for (int k = 0; k < NumCntr; k++) begin
                snap_d[k] = cnt_s[k];
                wm_d[k]   = (cnt_s[k] > wm_q[k]) ? cnt_s[k] : wm_q[k];
            end
        end else begin
            snap_d = snap_q;
            wm_d   = wm_q;
        end
        done_d = (state_q == StSnap) && (state_d != StClear);
        ack_d  = (state_d == StClear);
        busy_d = (state_d != StIdle);
        err_d  = err_q | (|cntr_err_s) | illegal_s;
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            size_q  <= {WinWidth{1'b0}};
            timer_q <= {WinWidth{1'b0}};
            snap_q  <= '0;
            wm_q    <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            timer_q <= timer_d;
            snap_q  <= snap_d;
            wm_q    <= wm_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < NumCntr; k++) begin : g_cntr
        entropy_src_cntr_reg #(
            .Width (RegWidth)
        ) u_cntr (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (cnt_clr_s),
            .inc_i  (cnt_inc_s[k]),
            .cnt_o  (cnt_s[k]),
            .err_o  (cntr_err_s[k])
        );
    end

    assign sw_clr_ack_o = ack_q;
    assign win_done_o   = done_q;
    assign snap_value_o = snap_q;
    assign watermark_o  = wm_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_entropy_src_cntr_win_ctrl.sv
// Bench for entropy_src_cntr_win_ctrl: table of windows with a snapshot scoreboard,
// plus directed sequences for enable drop, clear priority, reset and error injection.
module tb_entropy_src_cntr_win_ctrl;
    import entropy_src_pkg::*;

    localparam int NC = 4;
    localparam int RW = 4;
    localparam int WW = 16;

    typedef logic [NC-1:0][RW-1:0] vec_t;
    typedef struct { int unsigned due; vec_t snap; vec_t wm; } sb_t;
    typedef struct { int win; int n[NC]; vec_t snap; vec_t wm; } vec_rec_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          enable_i = 1'b0;
    logic [WW-1:0] win_size_i = '0;
    logic [NC-1:0] event_i = '0;
    logic          sw_clr_req_i = 1'b0;
    logic          sw_clr_ack_o, win_done_o, busy_o, err_o;
    vec_t          snap_value_o, watermark_o;

    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          done_cnt = 0;
    sb_t         sb_q[$];
    vec_rec_t    tbl[6];

    entropy_src_cntr_win_ctrl #(
        .NumCntr  (NC),
        .RegWidth (RW),
        .WinWidth (WW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .win_size_i   (win_size_i),
        .event_i      (event_i),
        .sw_clr_req_i (sw_clr_req_i),
        .sw_clr_ack_o (sw_clr_ack_o),
        .win_done_o   (win_done_o),
        .snap_value_o (snap_value_o),
        .watermark_o  (watermark_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic vec_t v(input int a, input int b, input int c, input int d);
        vec_t x;
        x[0] = RW'(a); x[1] = RW'(b); x[2] = RW'(c); x[3] = RW'(d);
        return x;
    endfunction

    function automatic vec_rec_t mk(input int win, input int n0, input int n1, input int n2,
                                    input int n3, input vec_t s, input vec_t w);
        vec_rec_t r;
        r.win = win;
        r.n[0] = n0; r.n[1] = n1; r.n[2] = n2; r.n[3] = n3;
        r.snap = s;
        r.wm = w;
        return r;
    endfunction

    // Scoreboard: every win_done_o must match the oldest pending window, on the expected cycle.
    initial forever begin
        sb_t e;
        @(negedge clk_i);
        if (rst_ni === 1'b1) begin
            if (win_done_o === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    chk_eq("unexpected_done", {31'd0, win_done_o}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk_eq("done_cycle", cyc, e.due);
                    chk_eq("snap_value", snap_value_o, e.snap);
                    chk_eq("watermark", watermark_o, e.wm);
                end
            end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
                chk_eq("missing_done", {31'd0, win_done_o}, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_run(input int win);
        enable_i = 1'b1;
        win_size_i = WW'(win);
        event_i = '0;
        @(negedge clk_i);
    endtask

    // Drives one window from its first RUN cycle through SNAP; events in SNAP must be dropped.
    task automatic run_window(input vec_rec_t r, input int next_win, input bit next_en);
        sb_t e;
        for (int k = 0; k < r.win; k++) begin
            for (int c = 0; c < NC; c++) event_i[c] = (k >= r.win - r.n[c]);
            win_size_i = WW'($urandom_range(0, 60));
            enable_i = 1'b1;
            @(negedge clk_i);
        end
        event_i = '1;
        win_size_i = WW'(next_win);
        enable_i = next_en;
        e.due = cyc + 1;
        e.snap = r.snap;
        e.wm = r.wm;
        sb_q.push_back(e);
        @(negedge clk_i);
        event_i = '0;
    endtask

    initial begin
        int ack_total;
        int dc;

        tbl[0] = mk(5,  5, 0,  2, 1, v(5, 0, 2, 1),  v(5, 0, 2, 1));
        tbl[1] = mk(9,  9, 4,  0, 9, v(9, 4, 0, 9),  v(9, 4, 2, 9));
        tbl[2] = mk(3,  3, 3,  3, 0, v(3, 3, 3, 0),  v(9, 4, 3, 9));
        tbl[3] = mk(8,  8, 1,  0, 2, v(8, 1, 0, 2),  v(9, 4, 3, 9));
        tbl[4] = mk(40, 0, 20, 40, 7, v(0, 15, 15, 7), v(9, 15, 15, 9));
        tbl[5] = mk(1,  1, 1,  0, 1, v(1, 1, 0, 1),  v(9, 15, 15, 9));

        repeat (2) @(negedge clk_i);
        chk_eq("reset_snap", snap_value_o, 32'd0);
        chk_eq("reset_wm", watermark_o, 32'd0);
        chk_eq("reset_flags", {28'd0, sw_clr_ack_o, win_done_o, busy_o, err_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        start_run(tbl[0].win);
        for (int i = 0; i < 6; i++) begin
            run_window(tbl[i], (i < 5) ? tbl[i + 1].win : 0, i < 5);
        end

        // Enable drop mid-window: back to IDLE, snapshots held, no done.
        start_run(10);
        for (int k = 0; k < 4; k++) begin
            event_i = '1;
            if (k == 2) chk_eq("busy_in_run", {31'd0, busy_o}, 32'd1);
            @(negedge clk_i);
        end
        enable_i = 1'b0;
        event_i = '1;
        @(negedge clk_i);
        chk_eq("drop_idle", {31'd0, busy_o}, 32'd0);
        chk_eq("drop_snap_held", snap_value_o, v(1, 1, 0, 1));
        chk_eq("drop_wm_held", watermark_o, v(9, 15, 15, 9));
        event_i = '0;
        enable_i = 1'b1;
        win_size_i = '0;
        repeat (3) @(negedge clk_i);
        chk_eq("zero_size_idle", {31'd0, busy_o}, 32'd0);
        start_run(4);
        run_window(mk(4, 4, 0, 0, 0, v(4, 0, 0, 0), v(9, 15, 15, 9)), 0, 1'b0);

        // Clear request in the final window cycle beats SNAP.
        start_run(6);
        for (int k = 0; k < 5; k++) begin
            event_i = 4'b0001;
            @(negedge clk_i);
        end
        event_i = '1;
        sw_clr_req_i = 1'b1;
        @(negedge clk_i);
        chk_eq("clr_ack", {31'd0, sw_clr_ack_o}, 32'd1);
        chk_eq("clr_snap", snap_value_o, 32'd0);
        chk_eq("clr_wm", watermark_o, 32'd0);
        ack_total = int'(sw_clr_ack_o);
        sw_clr_req_i = 1'b0;
        enable_i = 1'b0;
        event_i = '0;
        repeat (4) begin
            @(negedge clk_i);
            ack_total += int'(sw_clr_ack_o);
        end
        chk_eq("clr_ack_count", ack_total, 32'd1);
        chk_eq("clr_idle", {31'd0, busy_o}, 32'd0);

        // Reset in the middle of a window discards it.
        start_run(2);
        run_window(mk(2, 2, 0, 0, 0, v(2, 0, 0, 0), v(2, 0, 0, 0)), 10, 1'b1);
        repeat (3) begin
            event_i = '1;
            @(negedge clk_i);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk_eq("rst_snap", snap_value_o, 32'd0);
        chk_eq("rst_wm", watermark_o, 32'd0);
        chk_eq("rst_flags", {28'd0, sw_clr_ack_o, win_done_o, busy_o, err_o}, 32'd0);
        dc = done_cnt;
        enable_i = 1'b0;
        event_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (15) @(negedge clk_i);
        chk_eq("rst_no_done", done_cnt, dc);
        chk_eq("rst_idle", {31'd0, busy_o}, 32'd0);

        // Illegal state encoding.
        force dut.state_q = state_e'(4'b0011);
        @(negedge clk_i);
        release dut.state_q;
        @(negedge clk_i);
        chk_eq("err_illegal", {31'd0, err_o}, 32'd1);
        chk_eq("illegal_to_idle", {31'd0, busy_o}, 32'd0);
        repeat (5) @(negedge clk_i);
        chk_eq("err_illegal_sticky", {31'd0, err_o}, 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk_eq("err_cleared_by_reset", {31'd0, err_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Counter copy disagreement.
        force dut.g_cntr[1].u_cntr.cnt_q = 4'd5;
        @(negedge clk_i);
        release dut.g_cntr[1].u_cntr.cnt_q;
        repeat (3) @(negedge clk_i);
        chk_eq("err_cntr", {31'd0, err_o}, 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk_eq("err_cntr_reset", {31'd0, err_o}, 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        chk_eq("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
